// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Accepts a framed byte stream (LEN, LEN data bytes, CSUM) over a valid/ready
// handshake, writes the data bytes to instruction memory from address 0 upward,
// and holds the processor in reset until the frame checksum has been verified.
//
// Ports:
//   Clk, Reset      clock and synchronous active-high reset
//   In_Valid        source presents a byte on In_Data
//   In_Data         stream byte
//   In_Ready        loader accepts a byte this cycle (registered)
//   Mem_WE          instruction memory write pulse, one per data byte
//   Mem_Addr        write address
//   Mem_Data        write data
//   Load_Done       sticky: frame written and checksum good
//   Load_Error      sticky: length too large or checksum mismatch
//   Proc_Reset_n    active-low reset to the processor
//   Words_Loaded    number of data words written so far
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Load_Done,
  output logic              Load_Error,
  output logic              Proc_Reset_n,
  output logic [ADDR_W-1:0] Words_Loaded
);

  // Counter wide enough to hold any LEN value and any address plus one.
  localparam int unsigned CNT_W = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  len;
  logic [DATA_W-1:0] sum;
  logic              xfer;

  assign xfer         = In_Valid && In_Ready;
  assign Words_Loaded = ADDR_W'(count);

  // Frame parser with registered handshake, write port and status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_LEN;
      count        <= '0;
      len          <= '0;
      sum          <= '0;
      In_Ready     <= 1'b0;
      Mem_WE       <= 1'b0;
      Mem_Addr     <= '0;
      Mem_Data     <= '0;
      Load_Done    <= 1'b0;
      Load_Error   <= 1'b0;
      Proc_Reset_n <= 1'b0;
    end else begin
      Mem_WE <= 1'b0;
      case (state)
        S_LEN: begin
          In_Ready <= 1'b1;
          if (xfer) begin
            len   <= CNT_W'(In_Data);
            count <= '0;
            sum   <= '0;
            if (32'(In_Data) > DEPTH) begin
              state      <= S_ERR;
              In_Ready   <= 1'b0;
              Load_Error <= 1'b1;
            end else if (In_Data == '0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          In_Ready <= 1'b1;
          if (xfer) begin
            sum      <= sum + In_Data;
            count    <= count + CNT_W'(1);
            Mem_WE   <= 1'b1;
            Mem_Addr <= ADDR_W'(count);
            Mem_Data <= In_Data;
            if (count + CNT_W'(1) == len) begin
              state <= S_CSUM;
            end
          end
        end

        S_CSUM: begin
          In_Ready <= 1'b1;
          if (xfer) begin
            In_Ready <= 1'b0;
            if (In_Data == sum) begin
              state        <= S_DONE;
              Load_Done    <= 1'b1;
              Proc_Reset_n <= 1'b1;
            end else begin
              state      <= S_ERR;
              Load_Error <= 1'b1;
            end
          end
        end

        // Terminal states: only Reset leaves them.
        S_DONE, S_ERR: begin
          In_Ready <= 1'b0;
        end

        default: begin
          state    <= S_LEN;
          In_Ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: frame-level reference model, write scoreboard
// checked by an independent monitor, directed frames plus randomized frames.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              In_Valid;
  logic [DATA_W-1:0] In_Data;
  logic              In_Ready;
  logic              Mem_WE;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data;
  logic              Load_Done;
  logic              Load_Error;
  logic              Proc_Reset_n;
  logic [ADDR_W-1:0] Words_Loaded;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .In_Valid    (In_Valid),
    .In_Data     (In_Data),
    .In_Ready    (In_Ready),
    .Mem_WE      (Mem_WE),
    .Mem_Addr    (Mem_Addr),
    .Mem_Data    (Mem_Data),
    .Load_Done   (Load_Done),
    .Load_Error  (Load_Error),
    .Proc_Reset_n(Proc_Reset_n),
    .Words_Loaded(Words_Loaded)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge Clk) begin
    wr_t e;
    if (Mem_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected at cycle %0d",
                 Mem_Addr, Mem_Data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", int'(Mem_Addr), e.addr);
        check("write_data", int'(Mem_Data), e.data);
        check("write_cycle", cyc, e.cyc);
      end
    end
  end

  // Synchronous reset pulse followed by a check of every output's reset value.
  task automatic do_reset();
    @(negedge Clk);
    In_Valid = 1'b0;
    Reset    = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    exp_q.delete();
    check("rst_in_ready",     int'(In_Ready),     0);
    check("rst_mem_we",       int'(Mem_WE),       0);
    check("rst_mem_addr",     int'(Mem_Addr),     0);
    check("rst_mem_data",     int'(Mem_Data),     0);
    check("rst_load_done",    int'(Load_Done),    0);
    check("rst_load_error",   int'(Load_Error),   0);
    check("rst_proc_reset_n", int'(Proc_Reset_n), 0);
    check("rst_words",        int'(Words_Loaded), 0);
  endtask

  // Offer one byte until accepted; c is the cycle count seen just before the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int words, output int c, output bit ok);
    int waited;
    waited = 0;
    ok     = 1'b0;
    c      = 0;
    while (!ok && waited < 20) begin
      @(negedge Clk);
      In_Valid = 1'b1;
      In_Data  = b;
      c        = cyc;
      check("mid_proc_reset_n", int'(Proc_Reset_n), 0);
      check("mid_load_done",    int'(Load_Done),    0);
      check("mid_load_error",   int'(Load_Error),   0);
      check("mid_words",        int'(Words_Loaded), words);
      if (In_Ready === 1'b1) begin
        @(posedge Clk);
        ok = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: byte 0x%0h not accepted within 20 cycles", b);
    end
  endtask

  // Send frame_q; the expected outcome is derived from the frame rules alone.
  task automatic send_frame(input int stall_pct, input bit complete, output bit done_exp);
    int n;
    int sum;
    int words;
    int c;
    bit ok;
    n        = int'(frame_q[0]);
    words    = 0;
    done_exp = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
        @(negedge Clk);
        In_Valid = 1'b0;
        In_Data  = 8'($urandom);
      end
      send_byte(frame_q[i], words, c, ok);
      if (!ok) return;
      if (i >= 1 && i <= n) begin
        exp_q.push_back('{i - 1, int'(frame_q[i]), c + 1});
        words++;
      end
      if (i == 0 && n > DEPTH) break;
    end
    if (!complete) return;
    @(negedge Clk);
    In_Valid = 1'b0;
    sum = 0;
    if (n <= DEPTH) begin
      for (int i = 1; i <= n; i++) sum = (sum + int'(frame_q[i])) % 256;
      done_exp = (int'(frame_q[n + 1]) == sum);
    end
    check("end_load_done",    int'(Load_Done),    int'(done_exp));
    check("end_load_error",   int'(Load_Error),   int'(!done_exp));
    check("end_proc_reset_n", int'(Proc_Reset_n), int'(done_exp));
    check("end_in_ready",     int'(In_Ready),     0);
    check("end_words",        int'(Words_Loaded), (n > DEPTH) ? 0 : n);
    check("end_writes_left",  exp_q.size(),       0);
  endtask

  // Keep offering random bytes after the frame; nothing may change.
  task automatic sticky(input int cycles, input bit done);
    repeat (cycles) begin
      @(negedge Clk);
      In_Valid = 1'b1;
      In_Data  = 8'($urandom);
      check("sticky_in_ready", int'(In_Ready), 0);
    end
    @(negedge Clk);
    In_Valid = 1'b0;
    check("sticky_load_done",    int'(Load_Done),    int'(done));
    check("sticky_load_error",   int'(Load_Error),   int'(!done));
    check("sticky_proc_reset_n", int'(Proc_Reset_n), int'(done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit d;
    int n;
    int sum;
    Reset    = 1'b1;
    In_Valid = 1'b0;
    In_Data  = '0;
    repeat (2) @(negedge Clk);
    do_reset();

    // Nominal frame, back to back.
    frame_q = {8'h03, 8'h12, 8'h34, 8'h56, 8'h9C};
    send_frame(0, 1'b1, d);
    sticky(5, d);

    // Bad checksum (correct value wraps to 0x01).
    do_reset();
    frame_q = {8'h02, 8'hFF, 8'h02, 8'h00};
    send_frame(0, 1'b1, d);
    sticky(3, d);

    // Source stalls before every byte.
    do_reset();
    frame_q = {8'h03, 8'h12, 8'h34, 8'h56, 8'h9C};
    send_frame(100, 1'b1, d);
    sticky(2, d);

    // Empty frame.
    do_reset();
    frame_q = {8'h00, 8'h00};
    send_frame(0, 1'b1, d);
    sticky(2, d);

    // Length beyond DEPTH.
    do_reset();
    frame_q = {8'h05};
    send_frame(0, 1'b1, d);
    sticky(2, d);

    // Reset in the middle of a frame, then a fresh one-word frame.
    do_reset();
    frame_q = {8'h04, 8'hAA, 8'hBB};
    send_frame(0, 1'b0, d);
    do_reset();
    frame_q = {8'h01, 8'h77, 8'h77};
    send_frame(0, 1'b1, d);
    sticky(2, d);

    // Full-depth frame: last write lands on address DEPTH-1.
    do_reset();
    frame_q = {8'h04, 8'h01, 8'h02, 8'h03, 8'hF0, 8'hF6};
    send_frame(30, 1'b1, d);
    sticky(2, d);

    // Randomized frames: lengths 0..DEPTH+1, random data, random stalls and checksums.
    for (int k = 0; k < 40; k++) begin
      do_reset();
      n = int'($urandom_range(DEPTH + 1));
      frame_q = {};
      frame_q.push_back(8'(n));
      sum = 0;
      for (int i = 0; i < n; i++) begin
        frame_q.push_back(8'($urandom));
        sum = (sum + int'(frame_q[i + 1])) % 256;
      end
      if ($urandom_range(3) != 0) frame_q.push_back(8'(sum));
      else frame_q.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
      send_frame(30, 1'b1, d);
      sticky(2, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
